rv32m_div_unit: RTL and testbench
=================================

# rv32m_div_unit

Iterative radix-2 divider servicing DIV/DIVU/REM/REMU requests from the EX stage of the RV32ICM pipeline. EX raises a start request with operands. The unit holds `o_ctrl_Busy` so the hazard logic freezes PC, IFID, IDEX and EXMEM. It then returns a one-cycle `o_valid` with the result, which EX forwards into EXMEM. It is the responder side of the EX busy/stall interface.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; the iteration count equals `DATA_WIDTH`.
- `clk` in 1: clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `i_start` in 1: request; sampled only in IDLE and only when `i_Funct3[2]`=1.
- `i_Funct3` in 3: operation select.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - `i_Funct3[2]`=0 means MUL group; the request is ignored.
- `i_Dividend` in DATA_WIDTH: rs1 value, already forwarded.
- `i_Divisor` in DATA_WIDTH: rs2 value, already forwarded.
- `i_kill` in 1: pipeline flush; aborts any operation.
- `o_ctrl_Busy` out 1: stall request to hazard logic.
- `o_valid` out 1: result valid, one cycle.
- `o_Result` out DATA_WIDTH: quotient or remainder; held until the next accepted request.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, with `i_start` & `i_Funct3[2]` & ~`i_kill`:
  - Latch op, sign flags and |dividend|, |divisor|.
  - Absolute values apply only for signed ops. 0x80000000 stays 0x80000000 when treated as unsigned magnitude.
  - Divisor == 0: load special result, go to DONE.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: load overflow result, go to DONE.
  - Otherwise clear the remainder, set counter = DATA_WIDTH-1, go to CALC.
- CALC, one restoring step per cycle:
  - rem = {rem[W-2:0], dvd[W-1]}; dvd <<= 1.
  - If rem ≥ divisor (W+1-bit compare): rem -= divisor, quotient bit = 1.
  - When counter == 0, apply sign correction and go to DONE:
    - Quotient negated iff signed op and sign(dividend) ≠ sign(divisor).
    - Remainder negated iff signed op and dividend negative.
  - Register the selected value (quotient for DIV/DIVU, remainder for REM/REMU) into `o_Result` on that edge.
- DONE: `o_valid`=1 for exactly this cycle; go to IDLE unconditionally. `i_start` is ignored in DONE.
- Special results:
  - Divide by zero: quotient = all-ones, remainder = dividend.
  - Overflow: quotient = 0x80000000, remainder = 0.
- `i_kill` in any state: next state IDLE, no `o_valid`, `o_Result` unchanged.
- `o_ctrl_Busy` = (IDLE & `i_start` & `i_Funct3[2]` & ~`i_kill`) | CALC.
  - Combinational, so the stall applies in the same cycle the request is presented.
  - Busy is 0 in DONE, letting EX advance with the result.

## Timing
- Reset: state IDLE; `o_valid`=0, `o_ctrl_Busy`=0, `o_Result`=0; internal registers 0.
- Reset mid-operation aborts immediately; no `o_valid` follows.
- Normal latency: request sampled at edge E0, iterations on E1..E32, `o_valid` high in the cycle after E32. That is 33 cycles after E0 with DATA_WIDTH=32; busy is high for 33 cycles, including the request cycle.
- Special cases: `o_valid` in the cycle after E0; busy is high only in the request cycle.
- Back-to-back: the earliest next accept is the cycle after DONE.
- Simultaneous `i_start` and `i_kill` in IDLE: kill wins; the request is not accepted and busy stays 0.

## Structure
- Shared package `rv32m_pkg`:
  - Funct3 constants FUNCT3_DIV/DIVU/REM/REMU.
  - State encoding constants S_IDLE/S_CALC/S_DONE.
  - MULDIV opcode/funct7 (0000001), reused by the ID decoder and the future multiplier.
- Single module; no sub-module needed.
- Sign-correction negation is inline combinational logic feeding the `o_Result` register.

## Test plan
- DIVU 100 / 7: busy for 33 cycles, then `o_valid` with 14. REMU same operands returns 2.
- DIV 0xFFFFFFF9 (-7) / 2 returns 0xFFFFFFFD (-3). REM same operands returns 0xFFFFFFFF (-1). REM 7 / -2 returns 1.
- DIV 5 / 0 returns 0xFFFFFFFF and REM 5 / 0 returns 5, each with `o_valid` 1 cycle after the request edge. DIVU 5 / 0 returns 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000 and REM returns 0, both via the 1-cycle path. DIVU same operands returns 0 after the full 33 cycles.
- Kill and reset:
  - Start DIVU 1000 / 10, assert `i_kill` at cycle 10: busy drops next cycle, no `o_valid`.
  - A fresh DIVU 9 / 3 started immediately after returns 3.
  - Repeat with `n_rst` pulsed mid-CALC: all outputs return to 0.
- `i_start` with `i_Funct3`=000: no busy, no `o_valid`. Start asserted during DONE is ignored.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M constants: funct3 select codes, divider FSM encoding and the
// MULDIV opcode/funct7 pattern used by the ID decoder and the execution units.
package rv32m_pkg;

   // R-type OP opcode and the funct7 value that selects the M extension
   localparam logic [6:0] OPCODE_OP    = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Divide-group funct3 codes; bit 2 set marks the divide group
   localparam logic [2:0] FUNCT3_DIV  = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU = 3'b101;
   localparam logic [2:0] FUNCT3_REM  = 3'b110;
   localparam logic [2:0] FUNCT3_REMU = 3'b111;

   // Divider FSM state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Works on operand
// magnitudes and applies the sign fix-up on the final iteration. Divide-by-zero
// and signed overflow bypass the iterations and finish in a single cycle.
module rv32m_div_unit
   import rv32m_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_start,
   input  logic [2:0]            i_Funct3,
   input  logic [DATA_WIDTH-1:0] i_Dividend,
   input  logic [DATA_WIDTH-1:0] i_Divisor,
   input  logic                  i_kill,
   output logic                  o_ctrl_Busy,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_Result
);

   localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  op_rem_q, op_rem_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [DATA_WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
   logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;

   logic                  is_signed, sign_a, sign_b;
   logic [DATA_WIDTH-1:0] abs_a, abs_b;
   logic                  accept, div_zero, overflow;
   logic [DATA_WIDTH-1:0] special_res;
   logic [DATA_WIDTH:0]   rem_shift, rem_diff;
   logic                  q_bit;
   logic [DATA_WIDTH-1:0] rem_step, quo_step, quo_fin, rem_fin;

   // Request decode and operand magnitudes
   always_comb begin
      is_signed = ~i_Funct3[0];
      sign_a    = is_signed & i_Dividend[DATA_WIDTH-1];
      sign_b    = is_signed & i_Divisor[DATA_WIDTH-1];
      abs_a     = sign_a ? (~i_Dividend + 1'b1) : i_Dividend;
      abs_b     = sign_b ? (~i_Divisor + 1'b1) : i_Divisor;
      accept    = (state_q == S_IDLE) & i_start & i_Funct3[2] & ~i_kill;
      div_zero  = (i_Divisor == '0);
      overflow  = is_signed & (i_Dividend == MIN_NEG) & (i_Divisor == '1);
      if (div_zero) begin
         special_res = i_Funct3[1] ? i_Dividend : '1;
      end else begin
         special_res = i_Funct3[1] ? '0 : MIN_NEG;
      end
   end

   // One restoring step plus the sign-corrected final values
   always_comb begin
      // Remainder is kept one bit wider during the compare so no bit is lost
      rem_shift = {rem_q, dvd_q[DATA_WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, dsr_q};
      q_bit     = (rem_shift >= {1'b0, dsr_q});
      rem_step  = q_bit ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
      quo_step  = {dvd_q[DATA_WIDTH-2:0], q_bit};
      quo_fin   = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
      rem_fin   = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
   end

   // FSM and datapath next-state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_rem_d  = op_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      rem_d     = rem_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_rem_d  = i_Funct3[1];
               neg_quo_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               dvd_d     = abs_a;
               dsr_d     = abs_b;
               rem_d     = '0;
               cnt_d     = CNT_LAST;
               if (div_zero || overflow) begin
                  result_d = special_res;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = rem_step;
            dvd_d = quo_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               result_d = op_rem_q ? rem_fin : quo_fin;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A flush abandons the operation and leaves the last result in place
      if (i_kill) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_rem_q  <= op_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         rem_q     <= rem_d;
         result_q  <= result_d;
      end
   end

   // Busy covers the request cycle so the pipeline freezes immediately
   always_comb begin
      o_ctrl_Busy = accept | (state_q == S_CALC);
      o_valid     = (state_q == S_DONE) & ~i_kill;
      o_Result    = result_q;
   end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed self-checking bench for rv32m_div_unit.
module tb_rv32m_div_unit;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        i_start;
   logic [2:0]  i_Funct3;
   logic [31:0] i_Dividend;
   logic [31:0] i_Divisor;
   logic        i_kill;
   logic        o_ctrl_Busy;
   logic        o_valid;
   logic [31:0] o_Result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32m_div_unit #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_start    (i_start),
      .i_Funct3   (i_Funct3),
      .i_Dividend (i_Dividend),
      .i_Divisor  (i_Divisor),
      .i_kill     (i_kill),
      .o_ctrl_Busy(o_ctrl_Busy),
      .o_valid    (o_valid),
      .o_Result   (o_Result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it to o_valid; in request-cycle-plus-CALC
   // terms busy should be high for exactly exp_lat cycles.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int  busy_n;
      int  lat;
      bit  seen;
      @(negedge clk);
      i_start = 1'b1; i_Funct3 = f3; i_Dividend = a; i_Divisor = b;
      #1;
      busy_n = o_ctrl_Busy ? 1 : 0;
      lat    = 0;
      seen   = 1'b0;
      for (int c = 1; c <= 100 && !seen; c++) begin
         @(negedge clk);
         i_start = 1'b0;
         #1;
         if (o_valid) begin
            seen = 1'b1;
            lat  = c;
         end else if (o_ctrl_Busy) begin
            busy_n++;
         end
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, 32'(busy_n), 32'(exp_lat));
      chk({tag, "_res"}, o_Result, exp_res);
      @(negedge clk);
      #1;
      chk({tag, "_vone"}, 32'(o_valid), 32'd0);
   endtask

   // Watch n cycles and report how many carried o_valid
   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         #1;
         if (o_valid) cnt++;
      end
   endtask

   int vcnt;

   initial begin
      n_rst = 1'b0; i_start = 1'b0; i_Funct3 = 3'b000;
      i_Dividend = '0; i_Divisor = '0; i_kill = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_busy", 32'(o_ctrl_Busy), 32'd0);
      chk("rst_res", o_Result, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
      run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      run_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
      run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      run_op("divu_max16", 3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
      run_op("remu_max16", 3'b111, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);

      // Kill during CALC: busy drops, no valid, result kept
      @(negedge clk);
      i_start = 1'b1; i_Funct3 = 3'b101; i_Dividend = 32'd1000; i_Divisor = 32'd10;
      @(negedge clk);
      i_start = 1'b0;
      repeat (9) @(negedge clk);
      i_kill = 1'b1;
      @(negedge clk);
      i_kill = 1'b0;
      #1;
      chk("kill_busy", 32'(o_ctrl_Busy), 32'd0);
      count_valid(40, vcnt);
      chk("kill_novalid", 32'(vcnt), 32'd0);
      chk("kill_res", o_Result, 32'hF);
      run_op("after_kill", 3'b101, 32'd9, 32'd3, 32'd3, 33);

      // Reset pulse during CALC
      @(negedge clk);
      i_start = 1'b1; i_Funct3 = 3'b101; i_Dividend = 32'd1000; i_Divisor = 32'd10;
      @(negedge clk);
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("mrst_busy", 32'(o_ctrl_Busy), 32'd0);
      chk("mrst_valid", 32'(o_valid), 32'd0);
      chk("mrst_res", o_Result, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      count_valid(40, vcnt);
      chk("mrst_novalid", 32'(vcnt), 32'd0);
      run_op("after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 33);

      // MUL-group request is ignored
      @(negedge clk);
      i_start = 1'b1; i_Funct3 = 3'b000; i_Dividend = 32'd6; i_Divisor = 32'd3;
      #1;
      chk("mul_busy", 32'(o_ctrl_Busy), 32'd0);
      @(negedge clk);
      i_start = 1'b0;
      count_valid(5, vcnt);
      chk("mul_novalid", 32'(vcnt), 32'd0);

      // Start + kill together in IDLE: kill wins
      @(negedge clk);
      i_start = 1'b1; i_Funct3 = 3'b101; i_Dividend = 32'd9; i_Divisor = 32'd3; i_kill = 1'b1;
      #1;
      chk("sk_busy", 32'(o_ctrl_Busy), 32'd0);
      @(negedge clk);
      i_start = 1'b0; i_kill = 1'b0;
      count_valid(40, vcnt);
      chk("sk_novalid", 32'(vcnt), 32'd0);

      // Start held into DONE is ignored
      @(negedge clk);
      i_start = 1'b1; i_Funct3 = 3'b100; i_Dividend = 32'd7; i_Divisor = 32'd0;
      @(negedge clk);
      i_Funct3 = 3'b101; i_Dividend = 32'd100; i_Divisor = 32'd7;
      #1;
      chk("done_valid", 32'(o_valid), 32'd1);
      chk("done_busy", 32'(o_ctrl_Busy), 32'd0);
      chk("done_res", o_Result, 32'hFFFF_FFFF);
      @(negedge clk);
      i_start = 1'b0;
      #1;
      chk("done_ign_busy", 32'(o_ctrl_Busy), 32'd0);
      count_valid(40, vcnt);
      chk("done_ign_valid", 32'(vcnt), 32'd0);
      chk("done_ign_res", o_Result, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
